// File: rtl/hxd_pkg.sv
// hxd_pkg: definitions shared by the loader-side blocks.
//   cmd_t        - loader protocol command bytes understood by ram_rw
//   boot_state_t - boot sequencer FSM states
//   conf_byte()  - selects one byte of the 8-byte CONF_WR payload
package hxd_pkg;

  typedef enum logic [7:0] {
    CPU_RST = 8'h2a,
    CPU_RUN = 8'h2b,
    CONF_WR = 8'h2c,
    CONF_RD = 8'h2d,
    DATA_WR = 8'h2e,
    DATA_RD = 8'h2f
  } cmd_t;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    CMD_RST    = 4'd1,
    CMD_CONF   = 4'd2,
    CONF_PAY   = 4'd3,
    CMD_DATA   = 4'd4,
    DATA_FETCH = 4'd5,
    DATA_SEND  = 4'd6,
    CMD_RUN    = 4'd7,
    PASS       = 4'd8
  } boot_state_t;

  // Payload is {length-1, base address}, sent least significant byte first,
  // so byte idx lives at bit offset 8*idx.
  function automatic logic [7:0] conf_byte(input logic [31:0] base,
                                           input logic [31:0] len_m1,
                                           input logic [2:0]  idx);
    logic [63:0] pay;
    pay = {len_m1, base};
    return pay[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/edge2en.sv
// edge2en: rising-edge detector producing a one-cycle enable pulse.
//   clk_i   - clock
//   rst_n_i - async active-low reset
//   sig_i   - synchronous level input
//   en_o    - registered pulse, high for one cycle after sig_i rises
module edge2en (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic en_o
);

  logic sig_d_r;
  logic en_r;

  // Delay the level by one cycle and flag low-to-high transitions.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sig_d_r <= 1'b0;
      en_r    <= 1'b0;
    end else begin
      sig_d_r <= sig_i;
      en_r    <= sig_i & ~sig_d_r;
    end
  end

  assign en_o = en_r;

endmodule

// File: rtl/boot_seq.sv
// boot_seq: autonomous boot sequencer in front of ram_rw's byte port.
// Replays CPU_RST, CONF_WR + 8-byte payload, DATA_WR + image bytes from the
// boot ROM and CPU_RUN, then forwards the external uart_rx stream untouched.
//   clk_i, rst_n_i        - clock, async active-low reset
//   boot_start_i          - level; rising edge requests a new boot sequence
//   ext_data_i/vld_i/rdy_o - byte stream from the external uart_rx
//   out_data_o/vld_o/rdy_i - byte stream towards ram_rw
//   rom_rd_addr_o/data_i  - boot ROM port, data valid one cycle after address
//   busy_o                - sequence in progress
//   done_o                - at least one sequence completed since reset
module boot_seq
  import hxd_pkg::*;
#(
  parameter int unsigned ROM_AW    = 12,
  parameter logic [31:0] BOOT_BASE = 32'h4000_0000,
  parameter logic [31:0] BOOT_LEN  = 32'd32,
  parameter bit          AUTO_BOOT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              boot_start_i,
  input  logic [7:0]        ext_data_i,
  input  logic              ext_vld_i,
  output logic              ext_rdy_o,
  output logic [7:0]        out_data_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [ROM_AW-1:0] rom_rd_addr_o,
  input  logic [7:0]        rom_rd_data_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [31:0]       LEN_M1    = BOOT_LEN - 32'd1;
  localparam logic [ROM_AW-1:0] LAST_ADDR = LEN_M1[ROM_AW-1:0];
  localparam logic [ROM_AW-1:0] ADDR_ONE  = {{(ROM_AW-1){1'b0}}, 1'b1};

  boot_state_t       state_r;
  logic [7:0]        out_data_r;
  logic              out_vld_r;
  logic [ROM_AW-1:0] addr_r;
  logic [2:0]        pay_cnt_r;
  logic              last_r;
  logic              busy_r;
  logic              done_r;
  logic              pend_r;
  logic              start_en_s;
  logic              acc_s;
  logic              take_s;
  logic              pass_s;

  edge2en u_start_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sig_i   (boot_start_i),
    .en_o    (start_en_s)
  );

  assign acc_s  = out_vld_r & out_rdy_i;
  // Never start while a pass-through byte is offered but not yet taken.
  assign take_s = pend_r & ~(ext_vld_i & ~out_rdy_i);
  assign pass_s = (state_r == PASS);

  // Boot FSM; each state names the byte currently held in out_data_r.
  // The ROM address runs one byte ahead of the holding register: it is
  // bumped when a byte is captured, so the next byte is already readable
  // by the time the current one is accepted (one idle cycle per data byte).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      out_data_r <= 8'h00;
      out_vld_r  <= 1'b0;
      addr_r     <= {ROM_AW{1'b0}};
      pay_cnt_r  <= 3'd0;
      last_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pend_r     <= 1'b0;
    end else begin
      if (start_en_s && !busy_r) begin
        pend_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (AUTO_BOOT) begin
            state_r    <= CMD_RST;
            out_data_r <= CPU_RST;
            out_vld_r  <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r <= PASS;
          end
        end
        CMD_RST: begin
          if (acc_s) begin
            out_data_r <= CONF_WR;
            state_r    <= CMD_CONF;
          end
        end
        CMD_CONF: begin
          if (acc_s) begin
            out_data_r <= conf_byte(BOOT_BASE, LEN_M1, 3'd0);
            pay_cnt_r  <= 3'd0;
            state_r    <= CONF_PAY;
          end
        end
        CONF_PAY: begin
          if (acc_s) begin
            if (pay_cnt_r == 3'd7) begin
              out_data_r <= DATA_WR;
              addr_r     <= {ROM_AW{1'b0}};
              state_r    <= CMD_DATA;
            end else begin
              out_data_r <= conf_byte(BOOT_BASE, LEN_M1, pay_cnt_r + 3'd1);
              pay_cnt_r  <= pay_cnt_r + 3'd1;
            end
          end
        end
        CMD_DATA: begin
          if (acc_s) begin
            out_vld_r <= 1'b0;
            state_r   <= DATA_FETCH;
          end
        end
        DATA_FETCH: begin
          out_data_r <= rom_rd_data_i;
          out_vld_r  <= 1'b1;
          last_r     <= (addr_r == LAST_ADDR);
          // Hold at the last address instead of wrapping.
          if (addr_r != LAST_ADDR) begin
            addr_r <= addr_r + ADDR_ONE;
          end
          state_r <= DATA_SEND;
        end
        DATA_SEND: begin
          if (acc_s) begin
            if (last_r) begin
              out_data_r <= CPU_RUN;
              state_r    <= CMD_RUN;
            end else begin
              out_vld_r <= 1'b0;
              state_r   <= DATA_FETCH;
            end
          end
        end
        CMD_RUN: begin
          if (acc_s) begin
            out_vld_r  <= 1'b0;
            out_data_r <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= PASS;
          end
        end
        PASS: begin
          if (take_s) begin
            pend_r     <= 1'b0;
            out_data_r <= CPU_RST;
            out_vld_r  <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= CMD_RST;
          end
        end
        default: begin
          out_vld_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // In PASS the port is a plain wire-through; elsewhere the FSM owns it.
  assign out_data_o    = pass_s ? ext_data_i : out_data_r;
  assign out_vld_o     = pass_s ? ext_vld_i  : out_vld_r;
  assign ext_rdy_o     = pass_s ? out_rdy_i  : 1'b0;
  assign rom_rd_addr_o = addr_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;

endmodule

// File: tb/tb_boot_seq.sv
module tb_boot_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: auto boot, 32-byte image. DUT B: manual boot, 1-byte image.
  logic        rst_n_a, start_a, ext_vld_a, ext_rdy_a, vld_a, rdy_a, busy_a, done_a;
  logic [7:0]  ext_data_a, out_a, rom_data_a;
  logic [11:0] addr_a;
  logic        rst_n_b, start_b, ext_vld_b, ext_rdy_b, vld_b, rdy_b, busy_b, done_b;
  logic [7:0]  ext_data_b, out_b, rom_data_b;
  logic [3:0]  addr_b;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int LEN_A = 32;
  localparam int LEN_B = 1;

  boot_seq #(.ROM_AW(12), .BOOT_BASE(BASE), .BOOT_LEN(32'd32), .AUTO_BOOT(1'b1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n_a), .boot_start_i(start_a),
    .ext_data_i(ext_data_a), .ext_vld_i(ext_vld_a), .ext_rdy_o(ext_rdy_a),
    .out_data_o(out_a), .out_vld_o(vld_a), .out_rdy_i(rdy_a),
    .rom_rd_addr_o(addr_a), .rom_rd_data_i(rom_data_a),
    .busy_o(busy_a), .done_o(done_a));

  boot_seq #(.ROM_AW(4), .BOOT_BASE(BASE), .BOOT_LEN(32'd1), .AUTO_BOOT(1'b0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n_b), .boot_start_i(start_b),
    .ext_data_i(ext_data_b), .ext_vld_i(ext_vld_b), .ext_rdy_o(ext_rdy_b),
    .out_data_o(out_b), .out_vld_o(vld_b), .out_rdy_i(rdy_b),
    .rom_rd_addr_o(addr_b), .rom_rd_data_i(rom_data_b),
    .busy_o(busy_b), .done_o(done_b));

  // Synchronous boot ROMs: data follows the address by one clock.
  logic [7:0] rom_a [0:4095];
  logic [7:0] rom_b [0:15];
  always @(posedge clk) begin
    rom_data_a <= rom_a[addr_a];
    rom_data_b <= rom_b[addr_b];
  end

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int checks = 0;
  int errors = 0;
  logic rnd_a = 1'b0, rnd_b = 1'b0;
  logic hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] held_a, held_b;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference: the loader byte stream a boot sequence must produce.
  task automatic push_seq(input int id, input int len, input int nbytes);
    logic [7:0] s[$];
    int lm1;
    lm1 = len - 1;
    s.push_back(8'h2a);
    s.push_back(8'h2c);
    for (int k = 0; k < 4; k++) s.push_back(8'((BASE >> (8 * k)) & 32'hff));
    for (int k = 0; k < 4; k++) s.push_back(8'((lm1 >> (8 * k)) & 255));
    s.push_back(8'h2e);
    for (int i = 0; i < len; i++) s.push_back((id == 0) ? rom_a[i] : rom_b[i]);
    s.push_back(8'h2b);
    for (int i = 0; i < nbytes && i < s.size(); i++) begin
      if (id == 0) qa.push_back(s[i]);
      else qb.push_back(s[i]);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold stability.
  always @(negedge clk) begin
    if (!rst_n_a) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) chk("a_hold_stable", {23'd0, vld_a, out_a}, {23'd0, 1'b1, held_a});
      if (vld_a && rdy_a) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_byte: got %h, expected no byte", out_a);
        end else begin
          chk("a_byte", out_a, qa.pop_front());
        end
      end
      if (busy_a) chk("a_ext_stalled", ext_rdy_a, 1'b0);
      if (busy_a && vld_a && out_a == 8'h2e) chk("a_data_cmd_addr", addr_a, 12'd0);
      hold_a = vld_a && !rdy_a;
      held_a = out_a;
    end
    if (!rst_n_b) begin
      hold_b = 1'b0;
    end else begin
      if (hold_b) chk("b_hold_stable", {23'd0, vld_b, out_b}, {23'd0, 1'b1, held_b});
      if (vld_b && rdy_b) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_byte: got %h, expected no byte", out_b);
        end else begin
          chk("b_byte", out_b, qb.pop_front());
        end
      end
      if (busy_b) chk("b_ext_stalled", ext_rdy_b, 1'b0);
      hold_b = vld_b && !rdy_b;
      held_b = out_b;
    end
  end

  // Random back-pressure generator.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_a) rdy_a = 1'($urandom_range(0, 1));
    if (rnd_b) rdy_b = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int id, input int which);
    if (id == 0) return (which == 0) ? busy_a : done_a;
    else return (which == 0) ? busy_b : done_b;
  endfunction

  // which: 0 = busy, 1 = done
  task automatic wait_for(input int id, input int which, input logic val, input int limit,
                          input string name, output int cyc);
    cyc = 0;
    while (sig_of(id, which) !== val && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (sig_of(id, which) !== val) begin
      errors++;
      $display("FAIL %s: got %b after %0d cycles, expected %b", name, sig_of(id, which), cyc, val);
    end
  endtask

  task automatic offer_ext(input int id, input logic [7:0] b, input int limit, input string name);
    int n;
    n = 0;
    if (id == 0) begin ext_data_a = b; ext_vld_a = 1'b1; end
    else begin ext_data_b = b; ext_vld_b = 1'b1; end
    @(negedge clk);
    while (((id == 0) ? ext_rdy_a : ext_rdy_b) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (((id == 0) ? ext_rdy_a : ext_rdy_b) !== 1'b1) begin
      errors++;
      $display("FAIL %s: ext byte %h not accepted, got rdy=0 after %0d cycles, expected rdy=1", name, b, n);
    end
    @(posedge clk);
    #1;
    if (id == 0) ext_vld_a = 1'b0;
    else ext_vld_b = 1'b0;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_out_data"}, out_a, 8'h00);
    chk({tag, "_out_vld"}, vld_a, 1'b0);
    chk({tag, "_ext_rdy"}, ext_rdy_a, 1'b0);
    chk({tag, "_rom_addr"}, addr_a, 12'd0);
    chk({tag, "_busy"}, busy_a, 1'b0);
    chk({tag, "_done"}, done_a, 1'b0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 4096; i++) rom_a[i] = (i < LEN_A) ? 8'(i) : 8'hee;
    for (int i = 0; i < 16; i++) rom_b[i] = 8'h5a ^ 8'(i);
    rst_n_a = 1'b0; start_a = 1'b0; ext_data_a = 8'h00; ext_vld_a = 1'b0; rdy_a = 1'b1;
    rst_n_b = 1'b0; start_b = 1'b0; ext_data_b = 8'h00; ext_vld_b = 1'b0; rdy_b = 1'b1;
    tick(3);
    chk_zero_a("a_reset");
    chk("b_reset_vld", vld_b, 1'b0);
    chk("b_reset_ext_rdy", ext_rdy_b, 1'b0);
    chk("b_reset_busy", busy_b, 1'b0);

    // Auto boot with a ready sink: 44 bytes, at most one idle per data byte.
    push_seq(0, LEN_A, LEN_A + 12);
    rst_n_a = 1'b1;
    wait_for(0, 1, 1'b1, 2000, "a_boot1_done", cyc);
    checks++;
    if (cyc > 1 + 12 + 2 * LEN_A + 4) begin
      errors++;
      $display("FAIL a_boot1_cycles: got %0d cycles, expected <= %0d", cyc, 1 + 12 + 2 * LEN_A + 4);
    end
    chk("a_boot1_busy", busy_a, 1'b0);
    chk("a_boot1_all_sent", qa.size(), 0);

    // Restart by edge with random back-pressure; ext byte stalled until PASS.
    rnd_a = 1'b1;
    push_seq(0, LEN_A, LEN_A + 12);
    start_a = 1'b1;
    wait_for(0, 0, 1'b1, 20, "a_boot2_start", cyc);
    start_a = 1'b0;
    qa.push_back(8'h2f);
    offer_ext(0, 8'h2f, 3000, "a_ext_after_boot");
    wait_for(0, 0, 1'b0, 10, "a_boot2_idle", cyc);
    rnd_a = 1'b0;
    rdy_a = 1'b1;
    tick(3);
    chk("a_boot2_all_sent", qa.size(), 0);
    chk("a_boot2_done", done_a, 1'b1);

    // Start request while a pass-through byte is stalled: deferred.
    rdy_a = 1'b0;
    ext_data_a = 8'h55;
    ext_vld_a = 1'b1;
    qa.push_back(8'h55);
    push_seq(0, LEN_A, LEN_A + 12);
    tick(1);
    start_a = 1'b1;
    tick(6);
    chk("a_start_deferred", busy_a, 1'b0);
    chk("a_pass_data", out_a, 8'h55);
    rdy_a = 1'b1;
    offer_ext(0, 8'h55, 5, "a_deferred_accept");
    chk("a_start_after_accept", busy_a, 1'b1);
    start_a = 1'b0;
    wait_for(0, 0, 1'b0, 2000, "a_boot3_end", cyc);
    chk("a_boot3_all_sent", qa.size(), 0);

    // Reset right after the 10th image byte, then a full restart.
    tick(2);
    push_seq(0, LEN_A, 11 + 10);
    start_a = 1'b1;
    wait_for(0, 0, 1'b1, 20, "a_boot4_start", cyc);
    start_a = 1'b0;
    cyc = 0;
    while (qa.size() != 0 && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("a_prefix_sent", qa.size(), 0);
    @(posedge clk);
    #1;
    rst_n_a = 1'b0;
    #1;
    chk_zero_a("a_midreset");
    tick(2);
    push_seq(0, LEN_A, LEN_A + 12);
    rst_n_a = 1'b1;
    wait_for(0, 1, 1'b1, 2000, "a_restart_done", cyc);
    chk("a_restart_busy", busy_a, 1'b0);
    chk("a_restart_all_sent", qa.size(), 0);

    // Manual-boot instance: pass-through after reset, then a 13-byte boot.
    rst_n_b = 1'b1;
    tick(3);
    chk("b_idle_busy", busy_b, 1'b0);
    chk("b_idle_done", done_b, 1'b0);
    chk("b_pass_ready", ext_rdy_b, 1'b1);
    qb.push_back(8'h3c);
    offer_ext(1, 8'h3c, 10, "b_pass_accept");
    push_seq(1, LEN_B, LEN_B + 12);
    rnd_b = 1'b1;
    start_b = 1'b1;
    wait_for(1, 0, 1'b1, 20, "b_boot_start", cyc);
    start_b = 1'b0;
    wait_for(1, 1, 1'b1, 500, "b_boot_done", cyc);
    chk("b_boot_busy", busy_b, 1'b0);
    rnd_b = 1'b0;
    tick(3);
    chk("b_all_sent", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
